// File: rtl/light_dance_engine.sv
// LED-pattern sequencer: WIDTH-bit pattern with parallel load, programmable step
// prescaler and four motion modes (shift-in, rotate left, rotate right, bounce).
module light_dance_engine #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] pdata,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] qdata,
    output logic             dir,
    output logic             step
);

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_ROTL   = 2'b01;
    localparam logic [1:0] MODE_ROTR   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    logic [WIDTH-1:0] qdata_reg;
    logic [WIDTH-1:0] qdata_next;
    logic             dir_reg;
    logic             dir_next;
    logic [DIV_W-1:0] cnt_reg;
    logic             step_reg;
    logic             tick;

    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] shift_in;

    // Per-bit neighbour selection for the three basic motions.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
            assign rot_l[gi] = qdata_reg[(gi + WIDTH - 1) % WIDTH];
            assign rot_r[gi] = qdata_reg[(gi + 1) % WIDTH];
            if (gi == WIDTH - 1) begin : g_msb
                assign shift_in[gi] = din;
            end else begin : g_low
                assign shift_in[gi] = qdata_reg[gi + 1];
            end
        end
    endgenerate

    assign tick = en && (cnt_reg == div);

    always_comb begin
        qdata_next = qdata_reg;
        dir_next   = dir_reg;
        case (mode)
            MODE_SHIFT: qdata_next = shift_in;
            MODE_ROTL:  qdata_next = rot_l;
            MODE_ROTR:  qdata_next = rot_r;
            MODE_BOUNCE: begin
                // Reaching an end flips direction and moves back the same step.
                if (!dir_reg) begin
                    if (qdata_reg[WIDTH-1]) begin
                        dir_next   = 1'b1;
                        qdata_next = rot_r;
                    end else begin
                        qdata_next = rot_l;
                    end
                end else begin
                    if (qdata_reg[0]) begin
                        dir_next   = 1'b0;
                        qdata_next = rot_l;
                    end else begin
                        qdata_next = rot_r;
                    end
                end
            end
            default: qdata_next = qdata_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            qdata_reg <= {{(WIDTH-1){1'b0}}, 1'b1};
            dir_reg   <= 1'b0;
            cnt_reg   <= '0;
            step_reg  <= 1'b0;
        end else if (load) begin
            // A coinciding tick is deliberately dropped.
            qdata_reg <= pdata;
            dir_reg   <= 1'b0;
            cnt_reg   <= '0;
            step_reg  <= 1'b0;
        end else if (tick) begin
            qdata_reg <= qdata_next;
            dir_reg   <= dir_next;
            cnt_reg   <= '0;
            step_reg  <= 1'b1;
        end else begin
            step_reg <= 1'b0;
            if (en) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign qdata = qdata_reg;
    assign dir   = dir_reg;
    assign step  = step_reg;

endmodule
